// File: rtl/systolic_pkg.sv
// Shared definitions for the weight-stationary systolic matrix unit:
// FSM state encoding, default geometry, latency and in-flight count width.
package systolic_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_COMPUTE,
      S_DRAIN
   } state_e;

   localparam int DEF_ROWS = 4;
   localparam int DEF_COLS = 4;

   // Acceptance-to-out_valid latency and in-flight count width
   // for the default geometry.
   localparam int LATENCY = DEF_ROWS + DEF_COLS;
   localparam int CNT_W   = $clog2(LATENCY + 1);

   function automatic int cnt_width(input int lat);
      return $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/pe_ws.sv
// Weight-stationary processing element: shift-loaded weight, data
// register passing right, psum register passing down.
// Ports: clk, reset, en (stall gate), load (weight shift), signed_mode,
//        wt_in/wt_out, data_in/data_out, psum_in/psum_out.
module pe_ws #(
   parameter int BIT_WIDTH = 8,
   parameter int ACC_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 load,
   input  logic                 signed_mode,
   input  logic [BIT_WIDTH-1:0] wt_in,
   output logic [BIT_WIDTH-1:0] wt_out,
   input  logic [BIT_WIDTH-1:0] data_in,
   output logic [BIT_WIDTH-1:0] data_out,
   input  logic [ACC_WIDTH-1:0] psum_in,
   output logic [ACC_WIDTH-1:0] psum_out
);

   localparam int PW = 2 * BIT_WIDTH;

   logic [BIT_WIDTH-1:0] wt_q, wt_d;
   logic [BIT_WIDTH-1:0] data_q, data_d;
   logic [ACC_WIDTH-1:0] psum_q, psum_d;
   logic [PW-1:0]        prod;
   logic [ACC_WIDTH-1:0] prod_ext;

   always_comb begin
      wt_d   = load ? wt_in : wt_q;
      data_d = en ? data_in : data_q;
      if (signed_mode) begin
         prod     = PW'($signed(data_in)) * PW'($signed(wt_q));
         prod_ext = ACC_WIDTH'($signed(prod));
      end else begin
         prod     = PW'(data_in) * PW'(wt_q);
         prod_ext = ACC_WIDTH'(prod);
      end
      psum_d = en ? psum_in + prod_ext : psum_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wt_q   <= '0;
         data_q <= '0;
         psum_q <= '0;
      end else begin
         wt_q   <= wt_d;
         data_q <= data_d;
         psum_q <= psum_d;
      end
   end

   assign wt_out   = wt_q;
   assign data_out = data_q;
   assign psum_out = psum_q;

endmodule

// File: rtl/systolic_mmu_ws.sv
// ROWS x COLS weight-stationary systolic array: out[c] = sum_r d[r]*W[r][c].
// Ports: clk, reset, signed_mode, wt_valid/wt_ready/wt_in (weight rows),
//        in_valid/in_ready/data_in (vectors), out_valid/out_ready/acc_out
//        (results), busy.
module systolic_mmu_ws
   import systolic_pkg::*;
#(
   parameter int ROWS      = DEF_ROWS,
   parameter int COLS      = DEF_COLS,
   parameter int BIT_WIDTH = 8,
   parameter int ACC_WIDTH = 24
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      signed_mode,
   input  logic                      wt_valid,
   output logic                      wt_ready,
   input  logic [COLS*BIT_WIDTH-1:0] wt_in,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ROWS*BIT_WIDTH-1:0] data_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [COLS*ACC_WIDTH-1:0] acc_out,
   output logic                      busy
);

   localparam int BW   = BIT_WIDTH;
   localparam int AW   = ACC_WIDTH;
   localparam int LAT  = ROWS + COLS;
   localparam int CW   = cnt_width(LAT);
   localparam int WC_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   state_e           state_q, state_d;
   logic             wt_ready_q, wt_ready_d;
   logic             sm_q, sm_d;
   logic [WC_W-1:0]  wc_q, wc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [LAT-1:0]   vld_q, vld_d;
   logic [COLS*AW-1:0] acc_q, acc_d;

   logic en, in_hs, wt_hs, out_hs;

   logic [BW-1:0] row_in  [ROWS];
   logic [BW-1:0] d_h     [ROWS][COLS];
   logic [BW-1:0] w_v     [ROWS][COLS];
   logic [AW-1:0] p_v     [ROWS][COLS];
   logic [AW-1:0] col_sum [COLS];
   logic [AW-1:0] col_out [COLS];

   // A result waiting for a consumer freezes the whole datapath.
   assign en     = !(vld_q[LAT-1] && !out_ready);
   assign in_hs  = in_valid && in_ready;
   assign wt_hs  = wt_valid && wt_ready_q;
   assign out_hs = vld_q[LAT-1] && out_ready;

   assign in_ready  = (state_q == S_COMPUTE) && en;
   assign wt_ready  = wt_ready_q;
   assign out_valid = vld_q[LAT-1];
   assign acc_out   = acc_q;
   assign busy      = (state_q != S_IDLE) || (cnt_q != '0);

   always_comb begin
      state_d = state_q;
      sm_d    = sm_q;
      wc_d    = wc_q;
      unique case (state_q)
         S_IDLE: begin
            if (wt_hs) begin
               sm_d    = signed_mode;
               wc_d    = WC_W'(1);
               state_d = (ROWS == 1) ? S_COMPUTE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (wt_hs) begin
               if (wc_q == WC_W'(ROWS - 1)) begin
                  state_d = S_COMPUTE;
                  wc_d    = '0;
               end else begin
                  wc_d = wc_q + WC_W'(1);
               end
            end
         end
         S_COMPUTE: begin
            if (wt_valid) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // Old weights stay live until every in-flight vector is out.
            if (cnt_q == '0) begin
               state_d = S_LOAD;
               wc_d    = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      wt_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
      cnt_d      = cnt_q + CW'(in_hs) - CW'(out_hs);
      vld_d      = en ? {vld_q[LAT-2:0], in_hs} : vld_q;
      acc_d      = acc_q;
      if (en) begin
         for (int c = 0; c < COLS; c++)
            acc_d[c*AW +: AW] = col_out[c];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wt_ready_q <= 1'b1;
         sm_q       <= 1'b0;
         wc_q       <= '0;
         cnt_q      <= '0;
         vld_q      <= '0;
         acc_q      <= '0;
      end else begin
         state_q    <= state_d;
         wt_ready_q <= wt_ready_d;
         sm_q       <= sm_d;
         wc_q       <= wc_d;
         cnt_q      <= cnt_d;
         vld_q      <= vld_d;
         acc_q      <= acc_d;
      end
   end

   // Input skew: row r reaches column 0 r cycles after acceptance.
   // Bubbles carry zero so idle slots stay clean.
   for (genvar r = 0; r < ROWS; r++) begin : g_skew
      logic [BW-1:0] din;
      assign din = in_hs ? data_in[r*BW +: BW] : '0;
      if (r == 0) begin : g_direct
         assign row_in[r] = din;
      end else begin : g_sr
         logic [BW-1:0] sk_q [r];
         logic [BW-1:0] sk_d [r];
         always_comb begin
            for (int k = 0; k < r; k++) sk_d[k] = sk_q[k];
            if (en) begin
               sk_d[0] = din;
               for (int k = 1; k < r; k++) sk_d[k] = sk_q[k-1];
            end
         end
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int k = 0; k < r; k++) sk_q[k] <= '0;
            end else begin
               for (int k = 0; k < r; k++) sk_q[k] <= sk_d[k];
            end
         end
         assign row_in[r] = sk_q[r-1];
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_top
      assign w_v[0][c] = wt_in[c*BW +: BW];
      assign p_v[0][c] = '0;
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign d_h[r][0] = row_in[r];
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic [BW-1:0] d_o, w_o;
         logic [AW-1:0] p_o;
         pe_ws #(
            .BIT_WIDTH (BW),
            .ACC_WIDTH (AW)
         ) u_pe (
            .clk         (clk),
            .reset       (reset),
            .en          (en),
            .load        (wt_hs),
            .signed_mode (sm_q),
            .wt_in       (w_v[r][c]),
            .wt_out      (w_o),
            .data_in     (d_h[r][c]),
            .data_out    (d_o),
            .psum_in     (p_v[r][c]),
            .psum_out    (p_o)
         );
         if (c < COLS - 1) begin : g_dr
            assign d_h[r][c+1] = d_o;
         end else begin : g_de
            logic [BW-1:0] d_unused;
            assign d_unused = d_o;
         end
         if (r < ROWS - 1) begin : g_dn
            assign w_v[r+1][c] = w_o;
            assign p_v[r+1][c] = p_o;
         end else begin : g_bot
            logic [BW-1:0] w_unused;
            assign w_unused   = w_o;
            assign col_sum[c] = p_o;
         end
      end
   end

   // Output deskew: column c waits COLS-1-c cycles so all columns
   // of one vector line up at the output register.
   for (genvar c = 0; c < COLS; c++) begin : g_dsk
      localparam int N = COLS - 1 - c;
      if (N == 0) begin : g_direct
         assign col_out[c] = col_sum[c];
      end else begin : g_sr
         logic [AW-1:0] ds_q [N];
         logic [AW-1:0] ds_d [N];
         always_comb begin
            for (int k = 0; k < N; k++) ds_d[k] = ds_q[k];
            if (en) begin
               ds_d[0] = col_sum[c];
               for (int k = 1; k < N; k++) ds_d[k] = ds_q[k-1];
            end
         end
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int k = 0; k < N; k++) ds_q[k] <= '0;
            end else begin
               for (int k = 0; k < N; k++) ds_q[k] <= ds_d[k];
            end
         end
         assign col_out[c] = ds_q[N-1];
      end
   end

endmodule

// File: tb/tb_systolic_mmu_ws.sv
// Self-checking bench for systolic_mmu_ws: scoreboard of expected
// result vectors, one task per scenario.
module tb_systolic_mmu_ws;
   import systolic_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_mode;
   logic        wt_valid, wt_ready;
   logic [31:0] wt_in;
   logic        in_valid, in_ready;
   logic [31:0] data_in;
   logic        out_valid, out_ready;
   logic [95:0] acc_out;
   logic        busy;

   logic        w16_valid, w16_ready;
   logic [31:0] w16_in;
   logic        in16_valid, in16_ready;
   logic [31:0] d16;
   logic        out16_valid, out16_ready;
   logic [63:0] acc16;
   logic        busy16;

   int checks = 0;
   int errors = 0;
   int rx = 0;
   logic [95:0] sb [$];
   logic [7:0]  wm [4][4];
   logic        msm;

   always #5 clk = ~clk;

   systolic_mmu_ws dut (
      .clk (clk), .reset (rst), .signed_mode (signed_mode),
      .wt_valid (wt_valid), .wt_ready (wt_ready), .wt_in (wt_in),
      .in_valid (in_valid), .in_ready (in_ready), .data_in (data_in),
      .out_valid (out_valid), .out_ready (out_ready),
      .acc_out (acc_out), .busy (busy)
   );

   systolic_mmu_ws #(.ACC_WIDTH (16)) dut16 (
      .clk (clk), .reset (rst), .signed_mode (1'b0),
      .wt_valid (w16_valid), .wt_ready (w16_ready), .wt_in (w16_in),
      .in_valid (in16_valid), .in_ready (in16_ready), .data_in (d16),
      .out_valid (out16_valid), .out_ready (out16_ready),
      .acc_out (acc16), .busy (busy16)
   );

   function automatic logic [95:0] model(input logic [31:0] d);
      logic [95:0] res;
      longint s, a, b;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         s = 0;
         for (int r = 0; r < 4; r++) begin
            a = longint'(d[r*8 +: 8]);
            b = longint'(wm[r][c]);
            if (msm) begin
               if (a > 127) a -= 256;
               if (b > 127) b -= 256;
            end
            s += a * b;
         end
         res[c*24 +: 24] = s[23:0];
      end
      return res;
   endfunction

   task automatic monitor();
      logic [95:0] e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            checks++;
            rx++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_extra got=%h required none", acc_out);
            end else begin
               e = sb.pop_front();
               if (acc_out !== e) begin
                  errors++;
                  $display("FAIL sb_result got=%h required=%h", acc_out, e);
               end
            end
         end
      end
   endtask

   task automatic load_weights();
      for (int k = 0; k < 4; k++) begin
         int n = 0;
         wt_valid = 1'b1;
         for (int c = 0; c < 4; c++) wt_in[c*8 +: 8] = wm[3-k][c];
         @(negedge clk);
         while (!wt_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!wt_ready) begin
            checks++;
            errors++;
            $display("FAIL wt_ready_timeout got=0 required=1");
         end
         @(posedge clk);
         #1;
      end
      wt_valid = 1'b0;
   endtask

   task automatic send_vec(input logic [31:0] d, input logic [95:0] exp);
      int n = 0;
      in_valid = 1'b1;
      data_in  = d;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout got=0 required=1");
      end else begin
         sb.push_back(exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain left=%0d required=0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      wt_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks += 5;
      if (wt_ready !== 1'b1) begin errors++;
         $display("FAIL rst_wt_ready got=%b required=1", wt_ready); end
      if (in_ready !== 1'b0) begin errors++;
         $display("FAIL rst_in_ready got=%b required=0", in_ready); end
      if (out_valid !== 1'b0) begin errors++;
         $display("FAIL rst_out_valid got=%b required=0", out_valid); end
      if (acc_out !== 96'h0) begin errors++;
         $display("FAIL rst_acc_out got=%h required=0", acc_out); end
      if (busy !== 1'b0) begin errors++;
         $display("FAIL rst_busy got=%b required=0", busy); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks += 2;
      if (wt_ready !== 1'b1) begin errors++;
         $display("FAIL idle_wt_ready got=%b required=1", wt_ready); end
      if (busy !== 1'b0) begin errors++;
         $display("FAIL idle_busy got=%b required=0", busy); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_identity();
      int n = 0;
      msm = 1'b0;
      signed_mode = 1'b0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) wm[r][c] = (r == c) ? 8'd1 : 8'd0;
      load_weights();
      @(negedge clk);
      checks += 2;
      if (in_ready !== 1'b1) begin errors++;
         $display("FAIL compute_in_ready got=%b required=1", in_ready); end
      if (busy !== 1'b1) begin errors++;
         $display("FAIL compute_busy got=%b required=1", busy); end
      @(posedge clk);
      #1;
      send_vec(32'h04030201, {24'd4, 24'd3, 24'd2, 24'd1});
      in_valid = 1'b0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      checks++;
      if (n != LATENCY) begin errors++;
         $display("FAIL latency got=%0d required=%0d", n, LATENCY); end
      wait_drain();
   endtask

   task automatic test_modes();
      apply_reset();
      msm = 1'b1;
      signed_mode = 1'b1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) wm[r][c] = 8'hFF;
      load_weights();
      send_vec(32'h80808080, {4{24'h000200}});
      in_valid = 1'b0;
      wait_drain();
      apply_reset();
      msm = 1'b0;
      signed_mode = 1'b0;
      load_weights();
      send_vec(32'h80808080, {4{24'h01FE00}});
      in_valid = 1'b0;
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int base;
      apply_reset();
      msm = 1'b1;
      signed_mode = 1'b1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) wm[r][c] = 8'($urandom);
      load_weights();
      base = rx;
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               logic [31:0] d;
               d = $urandom;
               send_vec(d, model(d));
            end
            in_valid = 1'b0;
         end
         begin
            int n = 0;
            logic [95:0] held;
            @(negedge clk);
            while (!out_valid && n < 100) begin
               @(negedge clk);
               n++;
            end
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            held = acc_out;
            checks += 2;
            if (out_valid !== 1'b1) begin errors++;
               $display("FAIL stall_valid got=%b required=1", out_valid); end
            if (in_ready !== 1'b0) begin errors++;
               $display("FAIL stall_in_ready got=%b required=0", in_ready); end
            repeat (4) begin
               @(posedge clk);
               #1;
               @(negedge clk);
               checks++;
               if (acc_out !== held) begin errors++;
                  $display("FAIL stall_hold got=%h required=%h",
                           acc_out, held); end
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain();
      checks++;
      if (rx - base != 16) begin errors++;
         $display("FAIL b2b_count got=%0d required=16", rx - base); end
   endtask

   task automatic test_reload();
      int base, n;
      logic [7:0] wb [4][4];
      logic [31:0] d;
      base = rx;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) wb[r][c] = 8'($urandom);
      for (int i = 0; i < 2; i++) begin
         d = $urandom;
         send_vec(d, model(d));
      end
      wt_valid = 1'b1;
      for (int c = 0; c < 4; c++) wt_in[c*8 +: 8] = wb[3][c];
      d = $urandom;
      send_vec(d, model(d));
      in_valid = 1'b0;
      n = 0;
      while (rx < base + 3 && n < 100) begin
         @(negedge clk);
         n++;
         checks += 2;
         if (wt_ready !== 1'b0) begin errors++;
            $display("FAIL drain_wt_ready got=%b required=0", wt_ready); end
         if (in_ready !== 1'b0) begin errors++;
            $display("FAIL drain_in_ready got=%b required=0", in_ready); end
      end
      checks++;
      if (rx < base + 3) begin errors++;
         $display("FAIL drain_results got=%0d required=3", rx - base); end
      @(posedge clk);
      #1;
      wm = wb;
      load_weights();
      for (int i = 0; i < 2; i++) begin
         d = $urandom;
         send_vec(d, model(d));
      end
      in_valid = 1'b0;
      wait_drain();
   endtask

   task automatic test_reset_midstream();
      int n = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         logic [31:0] d;
         d = $urandom;
         send_vec(d, model(d));
      end
      in_valid = 1'b0;
      @(negedge clk);
      while (!out_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin errors++;
         $display("FAIL pre_rst_valid got=%b required=1", out_valid); end
      #2;
      rst = 1'b1;
      #1;
      checks += 5;
      if (out_valid !== 1'b0) begin errors++;
         $display("FAIL async_rst_valid got=%b required=0", out_valid); end
      if (acc_out !== 96'h0) begin errors++;
         $display("FAIL async_rst_acc got=%h required=0", acc_out); end
      if (busy !== 1'b0) begin errors++;
         $display("FAIL async_rst_busy got=%b required=0", busy); end
      if (wt_ready !== 1'b1) begin errors++;
         $display("FAIL async_rst_wt_ready got=%b required=1", wt_ready); end
      if (in_ready !== 1'b0) begin errors++;
         $display("FAIL async_rst_in_ready got=%b required=0", in_ready); end
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      msm = 1'b0;
      signed_mode = 1'b0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) wm[r][c] = 8'h00;
      load_weights();
      send_vec($urandom, 96'h0);
      in_valid = 1'b0;
      wait_drain();
   endtask

   task automatic test_wrap();
      logic [63:0] q16 [$];
      logic [63:0] e;
      int n;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         w16_valid = 1'b1;
         w16_in = 32'hFFFFFFFF;
         @(negedge clk);
         while (!w16_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         @(posedge clk);
         #1;
      end
      w16_valid = 1'b0;
      in16_valid = 1'b1;
      d16 = 32'hFFFFFFFF;
      n = 0;
      @(negedge clk);
      while (!in16_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (in16_ready) q16.push_back({4{16'hF804}});
      @(posedge clk);
      #1;
      in16_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out16_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!out16_valid || q16.size() == 0) begin
         errors++;
         $display("FAIL wrap_valid got=%b required=1", out16_valid);
      end else begin
         e = q16.pop_front();
         for (int c = 0; c < 4; c++) begin
            checks++;
            if (acc16[c*16 +: 16] !== e[c*16 +: 16]) begin errors++;
               $display("FAIL wrap_col%0d got=%h required=%h",
                        c, acc16[c*16 +: 16], e[c*16 +: 16]); end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      signed_mode = 1'b0;
      wt_valid    = 1'b0;
      wt_in       = '0;
      in_valid    = 1'b0;
      data_in     = '0;
      out_ready   = 1'b1;
      msm         = 1'b0;
      w16_valid   = 1'b0;
      w16_in      = '0;
      in16_valid  = 1'b0;
      d16         = '0;
      out16_ready = 1'b1;
      fork
         monitor();
      join_none
      test_reset();
      test_identity();
      test_modes();
      test_back_to_back();
      test_reload();
      test_reset_midstream();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
